// File: rtl/fetch_queue_if.sv
// Fetch/decode side bundle of the instruction fetch queue: two-wide enqueue from fetch,
// two-wide presentation and dequeue count from decode, plus branch flush.
interface fetch_queue_if #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic [1:0]            in_count;
  logic [INST_WIDTH-1:0] in_inst0;
  logic [ADDR_WIDTH-1:0] in_pc0;
  logic [INST_WIDTH-1:0] in_inst1;
  logic [ADDR_WIDTH-1:0] in_pc1;
  logic                  in_ready;
  logic                  out_valid0;
  logic [INST_WIDTH-1:0] out_inst0;
  logic [ADDR_WIDTH-1:0] out_pc0;
  logic                  out_valid1;
  logic [INST_WIDTH-1:0] out_inst1;
  logic [ADDR_WIDTH-1:0] out_pc1;
  logic [1:0]            deq_count;
  logic [CW-1:0]         occupancy;

  modport master (
    output flush, in_count, in_inst0, in_pc0, in_inst1, in_pc1, deq_count,
    input  in_ready, out_valid0, out_inst0, out_pc0, out_valid1, out_inst1, out_pc1, occupancy
  );

  modport slave (
    input  flush, in_count, in_inst0, in_pc0, in_inst1, in_pc1, deq_count,
    output in_ready, out_valid0, out_inst0, out_pc0, out_valid1, out_inst1, out_pc1, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Two-in/two-out circular instruction buffer; one cycle fetch-to-decode, outputs from registered state.
// Backpressure: in_ready only when two slots are free (no same-cycle dequeue credit); offers while not ready are dropped.
module fetch_queue #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail, head1, tail1;
  logic [CW-1:0] count, count_next;
  logic [1:0]    enq, deq, deq_req;
  logic          ready;

  assign ready = (count <= CW'(DEPTH - 2));

  always_comb begin
    enq = 2'd0;
    if (ready && !fq.flush) enq = (fq.in_count == 2'd3) ? 2'd2 : fq.in_count;
  end

  // Clamp dequeue to what is actually held so an eager decode never underflows.
  always_comb begin
    deq_req = (fq.deq_count == 2'd3) ? 2'd2 : fq.deq_count;
    deq     = (CW'(deq_req) > count) ? count[1:0] : deq_req;
  end

  assign head1      = head + PW'(1);
  assign tail1      = tail + PW'(1);
  assign count_next = count + CW'(enq) - CW'(deq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (fq.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(enq);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (enq != 2'd0) mem[tail]  <= '{pc: fq.in_pc0, inst: fq.in_inst0};
    if (enq == 2'd2) mem[tail1] <= '{pc: fq.in_pc1, inst: fq.in_inst1};
  end

  assign fq.in_ready   = ready;
  assign fq.out_valid0 = (count != '0);
  assign fq.out_valid1 = (count >= CW'(2));
  assign fq.out_inst0  = mem[head].inst;
  assign fq.out_pc0    = mem[head].pc;
  assign fq.out_inst1  = mem[head1].inst;
  assign fq.out_pc1    = mem[head1].pc;
  assign fq.occupancy  = count;
endmodule
